pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Physical-memory side of the 128-bit line interface driven by mp3_mod's memory port.
- Accepts one line read or write per handshake and returns pmem_resp after a programmable latency.
- Holds line storage internally, so it can replace the behavioural memory model in the top-level testbench and in FPGA bring-up.
- Synthesizable; strictly one outstanding request at a time.

Parameters:
- LATENCY, 4: cycles from the request-capture edge to the edge that raises pmem_resp; legal range 1..255.
- DEPTH_LINES, 4096: number of 128-bit lines stored; power of two, at most 4096.
- ADDR_WIDTH, 16: byte-address width of pmem_address.
- LINE_WIDTH, 128: line width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pmem_read  input  1  line read request; held by the initiator until pmem_resp.
- pmem_write  input  1  line write request; held by the initiator until pmem_resp.
- pmem_address  input  ADDR_WIDTH  byte address; bits [3:0] are ignored (line-aligned).
- pmem_wdata  input  LINE_WIDTH  write line; stable while pmem_write is high.
- pmem_resp  output  1  one-cycle completion pulse, registered.
- pmem_rdata  output  LINE_WIDTH  read line; valid in the pmem_resp cycle, held until the next read completes.
- pmem_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset: asynchronous, active-low, on rst_n, with one clock clk. While rst_n=0:
  - state=IDLE, pmem_resp=0, pmem_rdata=0, pmem_err=0, counter=0.
  - Storage contents are not cleared.
  - Reset during BUSY or RESP aborts the request; a pending write is not committed.
- Line index = pmem_address[ADDR_WIDTH-1:4] modulo DEPTH_LINES. Upper bits wrap silently.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On an edge with pmem_read|pmem_write=1, capture op, line index and wdata.
  - Load counter with LATENCY-1 and go to BUSY.
  - If both requests are high, treat the request as a write and set pmem_err.
- BUSY:
  - Counter decrements each edge.
  - On the edge with counter==0, go to RESP. On that same edge:
    - a write commits the captured wdata to storage;
    - a read loads pmem_rdata from storage.
  - pmem_resp is registered high on the same edge.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally and pmem_resp returns to 0.
  - Request lines sampled in RESP are ignored. The initiator drops its request after seeing resp, so no double response occurs.
- Latency:
  - Capture at edge T gives pmem_resp high from edge T+LATENCY to edge T+LATENCY+1.
  - Minimum back-to-back issue: next capture at edge T+LATENCY+2.
- Read-after-write to the same line returns the new data; the write commits before any later capture.
- Captured fields are used for the whole transaction. Input changes during BUSY do not affect the result.
- pmem_err is cleared only by reset.

Optional Feature:
- Macro: PMEM_PROTOCOL_CHECK_EN.
- When defined, in BUSY the block compares live inputs against the captured values each cycle. pmem_err is set if:
  - pmem_address[ADDR_WIDTH-1:4] changes;
  - the op changes;
  - either request drops before resp;
  - pmem_wdata changes during a write.
- The transaction still completes using the captured values.
- When undefined, none of this logic exists. pmem_err is set only by simultaneous read and write.

Decomposition:
- Shared package pmem_pkg:
  - state enum pmem_state_t {IDLE, BUSY, RESP};
  - constants LINE_BYTES=16 and OFFSET_BITS=4;
  - typedef pmem_line_t (logic [127:0]).
- One sub-module: pmem_line_array.
  - Single-port, DEPTH_LINES x LINE_WIDTH storage.
  - Synchronous write enable, registered read.
  - The FSM drives it so the read output lands on the RESP-entry edge.

Test Plan:
- Reset then write: LATENCY=4, write addr 16'h0040 with wdata 128'hDEAD...BEEF captured at edge 0 → pmem_resp high exactly for edge 4..5, pmem_err=0.
- Read-back: read 16'h004C, low bits ignored → pmem_rdata=128'hDEAD...BEEF in the resp cycle and held afterwards.
- Wrap: DEPTH_LINES=16, write line index 0 with A, then write addr 16'h0100 with B, then read 16'h0000 → returns B.
- Simultaneous: read=write=1 at 16'h0010 with wdata C → write is performed, pmem_err=1 and sticky, subsequent read of 16'h0010 → C.
- Reset mid-transaction: write D to 16'h0020, assert rst_n=0 while in BUSY, release, read 16'h0020 → old contents (not D), pmem_resp never pulsed for the aborted write.
- LATENCY=1 back-to-back reads held continuously → exactly one resp per transaction, resp spacing of 3 cycles; with PMEM_PROTOCOL_CHECK_EN defined, changing address mid-BUSY → pmem_err=1.

Source files
------------

// File: rtl/pmem_pkg.sv
// pmem_pkg: shared state encoding, line geometry and line type for the pmem line responder.
package pmem_pkg;
  localparam int LINE_BYTES = 16;
  localparam int OFFSET_BITS = 4;
  typedef logic [127:0] pmem_line_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: single-port line storage with synchronous write and a registered, held read output.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int DEPTH_LINES = 4096,
  parameter int LINE_WIDTH = 128,
  localparam int IW = DEPTH_LINES > 1 ? $clog2(DEPTH_LINES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [IW-1:0]         idx,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic [LINE_WIDTH-1:0] rdata
);
  logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: one-outstanding 128-bit line memory answering after LATENCY cycles.
// Defining PMEM_PROTOCOL_CHECK_EN adds a BUSY-time check that the initiator holds its request stable.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH_LINES = 4096,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_err
);
  localparam int IW = DEPTH_LINES > 1 ? $clog2(DEPTH_LINES) : 1;
  pmem_state_t state;
  logic [7:0] cnt;
  logic op_wr;
  logic [IW-1:0] idx;
  logic [LINE_WIDTH-1:0] wbuf;
  logic done;
  logic req_err;
  logic unused;
  assign unused = ^pmem_address;
  assign done = state == BUSY && cnt == '0;
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] tag;
  logic [1:0] req;
  assign req_err = state == BUSY && (pmem_address[ADDR_WIDTH-1:OFFSET_BITS] != tag ||
                   {pmem_read, pmem_write} != req || (op_wr && pmem_wdata != wbuf));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag <= '0;
      req <= '0;
    end else if (state == IDLE) begin
      tag <= pmem_address[ADDR_WIDTH-1:OFFSET_BITS];
      req <= {pmem_read, pmem_write};
    end
`else
  assign req_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pmem_resp <= 1'b0;
      pmem_err <= 1'b0;
      op_wr <= 1'b0;
      idx <= '0;
      wbuf <= '0;
    end else begin
      pmem_resp <= done;
      if ((state == IDLE && pmem_read && pmem_write) || req_err) pmem_err <= 1'b1;
      if (state == IDLE && (pmem_read || pmem_write)) begin
        op_wr <= pmem_write;
        idx <= pmem_address[OFFSET_BITS +: IW];
        wbuf <= pmem_wdata;
        cnt <= 8'(LATENCY - 1);
        state <= BUSY;
      end else if (state == BUSY) begin
        if (done) state <= RESP;
        else cnt <= cnt - 8'd1;
      end else if (state == RESP) state <= IDLE;
    end
  // storage acts only on the RESP-entry edge so the read lands with pmem_resp
  pmem_line_array #(.DEPTH_LINES(DEPTH_LINES), .LINE_WIDTH(LINE_WIDTH)) u_lines (
    .clk(clk),
    .rst_n(rst_n),
    .we(done && op_wr),
    .re(done && !op_wr),
    .idx(idx),
    .wdata(wbuf),
    .rdata(pmem_rdata)
  );
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: scoreboard bench driving a LATENCY=4 and a LATENCY=1 responder (16 lines each).
module tb_pmem_responder;
  typedef struct {bit chk; logic [127:0] data; int at;} exp_t;
  localparam logic [127:0] DB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] LA = 128'hAAAA_0001_0002_0003_0004_0005_0006_0007;
  localparam logic [127:0] LB = 128'hBBBB_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] LC = 128'hCCCC_CAFE_F00D_1234_5678_9ABC_DEF0_0C0C;
  localparam logic [127:0] LD = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
  localparam logic [127:0] LE = 128'hEEEE_0123_4567_89AB_CDEF_FEDC_BA98_7654;
  localparam logic [127:0] LF = 128'hF0F0_1234_ABCD_5678_EF01_2345_6789_FFFF;
`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic rd = 0, wr = 0, f_rd = 0, f_wr = 0;
  logic [15:0] addr = '0, f_addr = '0;
  logic [127:0] wdata = '0, f_wdata = '0;
  logic resp, err, f_resp, f_err;
  logic [127:0] rdata, f_rdata;
  int cyc = 0, total = 0, bad = 0;
  exp_t sq[$], fq[$];
  logic [127:0] mdl[16], fmdl[16];

  pmem_responder #(.LATENCY(4), .DEPTH_LINES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd), .pmem_write(wr), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp), .pmem_rdata(rdata), .pmem_err(err));
  pmem_responder #(.LATENCY(1), .DEPTH_LINES(16)) u_fast (
    .clk(clk), .rst_n(rst_n), .pmem_read(f_rd), .pmem_write(f_wr), .pmem_address(f_addr),
    .pmem_wdata(f_wdata), .pmem_resp(f_resp), .pmem_rdata(f_rdata), .pmem_err(f_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (resp) begin
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected cycle=%0d got resp=1 want 0", cyc);
      end else begin
        e = sq.pop_front();
        if (cyc !== e.at) begin
          bad++;
          $display("FAIL resp_time got cycle %0d want %0d", cyc, e.at);
        end
        if (e.chk) begin
          total++;
          if (rdata !== e.data) begin
            bad++;
            $display("FAIL rdata got %h want %h", rdata, e.data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon_fast
    exp_t e;
    if (f_resp) begin
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL f_resp_unexpected cycle=%0d got resp=1 want 0", cyc);
      end else begin
        e = fq.pop_front();
        if (cyc !== e.at) begin
          bad++;
          $display("FAIL f_resp_time got cycle %0d want %0d", cyc, e.at);
        end
        if (e.chk) begin
          total++;
          if (f_rdata !== e.data) begin
            bad++;
            $display("FAIL f_rdata got %h want %h", f_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic txn(input bit f, input logic r, input logic w, input logic [15:0] a,
                     input logic [127:0] d);
    int i, n;
    exp_t e;
    i = int'((a >> 4) % 16);
    @(negedge clk);
    if (w) begin
      if (f) fmdl[i] = d;
      else mdl[i] = d;
    end
    e.chk = r && !w;
    e.data = f ? fmdl[i] : mdl[i];
    e.at = cyc + 1 + (f ? 1 : 4);
    if (f) begin
      fq.push_back(e);
      f_rd = r; f_wr = w; f_addr = a; f_wdata = d;
    end else begin
      sq.push_back(e);
      rd = r; wr = w; addr = a; wdata = d;
    end
    n = 0;
    while (!(f ? f_resp : resp) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL txn_timeout addr=%h got no resp want resp within 20 cycles", a);
    end
    if (f) {f_rd, f_wr} = 2'b00;
    else {rd, wr} = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if (resp !== 1'b0) begin bad++; $display("FAIL reset_resp got %b want 0", resp); end
    total++;
    if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1;
  endtask

  task automatic test_write();
    txn(0, 0, 1, 16'h0040, DB);
    @(negedge clk);
    total++;
    if (resp !== 1'b0) begin bad++; $display("FAIL write_resp_width got %b want 0", resp); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL write_err got %b want 0", err); end
  endtask

  task automatic test_readback();
    txn(0, 1, 0, 16'h004C, '0);
    repeat (3) @(negedge clk);
    total++;
    if (rdata !== DB) begin bad++; $display("FAIL readback_hold got %h want %h", rdata, DB); end
  endtask

  task automatic test_wrap();
    txn(0, 0, 1, 16'h0000, LA);
    txn(0, 0, 1, 16'h0100, LB);
    txn(0, 1, 0, 16'h0000, '0);
    @(negedge clk);
    total++;
    if (rdata !== LB) begin bad++; $display("FAIL wrap got %h want %h", rdata, LB); end
  endtask

  task automatic test_simultaneous();
    txn(0, 1, 1, 16'h0010, LC);
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL both_err got %b want 1", err); end
    txn(0, 1, 0, 16'h0010, '0);
    @(negedge clk);
    total++;
    if (rdata !== LC) begin bad++; $display("FAIL both_data got %h want %h", rdata, LC); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_abort();
    txn(0, 0, 1, 16'h0020, LE);
    @(negedge clk);
    wr = 1; addr = 16'h0020; wdata = LD;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL abort_err got %b want 0", err); end
    total++;
    if (rdata !== '0) begin bad++; $display("FAIL abort_rdata got %h want 0", rdata); end
    wr = 0;
    rst_n = 1;
    repeat (6) @(negedge clk);
    txn(0, 1, 0, 16'h0020, '0);
    @(negedge clk);
    total++;
    if (rdata !== LE) begin bad++; $display("FAIL abort_old got %h want %h", rdata, LE); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int c0;
    txn(1, 0, 1, 16'h0050, LF);
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e.chk = 1; e.data = LF; e.at = c0 + 2 + 3 * k;
      fq.push_back(e);
    end
    f_rd = 1; f_addr = 16'h0050;
    repeat (12) @(negedge clk);
    f_rd = 0;
    repeat (2) @(negedge clk);
    total++;
    if (fq.size() != 0) begin bad++; $display("FAIL b2b_count got %0d pending want 0", fq.size()); end
    total++;
    if (f_err !== 1'b0) begin bad++; $display("FAIL b2b_err got %b want 0", f_err); end
  endtask

  task automatic test_protocol();
    exp_t e;
    @(negedge clk);
    e.chk = 1; e.data = fmdl[5]; e.at = cyc + 2;
    fq.push_back(e);
    f_rd = 1; f_addr = 16'h0050;
    @(negedge clk);
    f_addr = 16'h0060;
    @(negedge clk);
    f_rd = 0;
    @(negedge clk);
    total++;
    if (f_err !== EXP_ERR) begin bad++; $display("FAIL proto_err got %b want %b", f_err, EXP_ERR); end
    total++;
    if (fq.size() != 0) begin bad++; $display("FAIL proto_resp got %0d pending want 0", fq.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_wrap();
    test_simultaneous();
    test_reset_abort();
    test_back_to_back();
    test_protocol();
    repeat (4) @(negedge clk);
    total++;
    if (sq.size() != 0) begin bad++; $display("FAIL pending_resp got %0d want 0", sq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
